hitchhike_tx_scheduler: RTL and testbench

Packet-level controller for the backscatter data source. It drives that block's `trigger`, `sending`, `head` and `datacmd` inputs so each transmission is one preamble field followed by one payload field. Both fields are symbol-aligned to the data source's internal tick counter, and an enforced idle gap separates packets. It sits between the host/control logic (start/enable) and the data source, and reports status (busy, done, packet count).

---
 rtl/hitchhike_tx_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_hitchhike_tx_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hitchhike_tx_scheduler.sv
// -----------------------------------------------------------------------------
// hitchhike_tx_scheduler
//
// Packet-level controller for the backscatter data source. Each transmission
// is a preamble field (PREAMBLE_BITS symbols taken from PREAMBLE_PATTERN,
// MSB first) followed by a payload field (PAYLOAD_BITS symbols of the data
// source's rotating pattern). Both fields are aligned to a symbol counter
// that mirrors the data source's own tick counter. A packet is followed by a
// GAP_CYCLES-long idle gap with trigger low, which reloads the data source.
//
// Ports:
//   clock         in   single clock
//   reset         in   asynchronous, active-low reset
//   enable        in   global enable; low aborts any packet in flight
//   start         in   one-cycle packet request, sampled only in IDLE
//   trigger       out  high for the whole packet (preamble + payload)
//   sending       out  high during preamble and payload
//   head          out  current preamble bit (0 outside the preamble)
//   datacmd       out  0 = preamble (head), 1 = payload (pattern shift)
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse in the first gap cycle of a packet
//   packet_count  out  completed packets, wraps 16'hFFFF -> 0
//
// Optional feature (compile-time macro TX_REPEAT_EN):
//   defined   - at the end of the gap the block goes straight back to the
//               preamble while enable stays high (back-to-back packets).
//   undefined - the gap always returns to IDLE; one packet per start.
//
// All outputs are registered: they are decoded from the next-state values
// and captured on the same edge as the state, so there is no combinational
// path from inputs to outputs.
// -----------------------------------------------------------------------------
module hitchhike_tx_scheduler #(
  parameter int unsigned      SYMBOL_TICKS     = 50,
  parameter int unsigned      PREAMBLE_BITS    = 8,
  parameter logic [31:0]      PREAMBLE_PATTERN = 32'h000000A5,
  parameter int unsigned      PAYLOAD_BITS     = 144,
  parameter int unsigned      GAP_CYCLES       = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  output logic        trigger,
  output logic        sending,
  output logic        head,
  output logic        datacmd,
  output logic        busy,
  output logic        done,
  output logic [15:0] packet_count
);

  // Terminal values of the down/up counters.
  localparam logic [15:0] SYM_LAST = 16'(SYMBOL_TICKS - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_BITS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // Current state and counters.
  state_t      state;
  logic [15:0] sym_cnt;   // tick within the current symbol, 0..SYMBOL_TICKS-1
  logic [15:0] bit_cnt;   // symbols remaining in the current field
  logic [15:0] gap_cnt;   // gap cycles remaining

  // Next-state values.
  state_t      state_n;
  logic [15:0] sym_n;
  logic [15:0] bit_n;
  logic [15:0] gap_n;
  logic [15:0] count_n;
  logic        done_n;

  // Next output values, decoded from the next state.
  logic        trigger_n;
  logic        sending_n;
  logic        head_n;
  logic        datacmd_n;
  logic        busy_n;

  // End of the current symbol period.
  logic sym_end;
  assign sym_end = (sym_cnt == SYM_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in always_comb infers a latch.
    state_n = state;
    sym_n   = sym_cnt;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    count_n = packet_count;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && enable) begin
          state_n = ST_PREAMBLE;
          sym_n   = '0;
          bit_n   = PRE_LAST;
        end
      end

      ST_PREAMBLE: begin
        if (sym_end) begin
          sym_n = '0;
          if (bit_cnt == '0) begin
            state_n = ST_PAYLOAD;
            bit_n   = PAY_LAST;
          end else begin
            bit_n = bit_cnt - 16'd1;
          end
        end else begin
          sym_n = sym_cnt + 16'd1;
        end
      end

      ST_PAYLOAD: begin
        if (sym_end) begin
          sym_n = '0;
          if (bit_cnt == '0) begin
            // Last payload symbol finished: report completion on the same
            // edge that drops trigger.
            state_n = ST_GAP;
            gap_n   = GAP_LAST;
            done_n  = 1'b1;
            count_n = packet_count + 16'd1;
          end else begin
            bit_n = bit_cnt - 16'd1;
          end
        end else begin
          sym_n = sym_cnt + 16'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
`ifdef TX_REPEAT_EN
          // Back-to-back mode: the gap was the only spacing required.
          state_n = ST_PREAMBLE;
          sym_n   = '0;
          bit_n   = PRE_LAST;
`else
          state_n = ST_IDLE;
`endif
        end else begin
          gap_n = gap_cnt - 16'd1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Abort has priority over everything: no done, count untouched.
    if (!enable) begin
      state_n = ST_IDLE;
      sym_n   = '0;
      bit_n   = '0;
      gap_n   = '0;
      count_n = packet_count;
      done_n  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state (captured in the register below)
  // ---------------------------------------------------------------------------
  always_comb begin
    trigger_n = 1'b0;
    sending_n = 1'b0;
    head_n    = 1'b0;
    datacmd_n = 1'b0;
    busy_n    = (state_n != ST_IDLE);

    case (state_n)
      ST_PREAMBLE: begin
        trigger_n = 1'b1;
        sending_n = 1'b1;
        head_n    = PREAMBLE_PATTERN[bit_n[4:0]];
      end
      ST_PAYLOAD: begin
        trigger_n = 1'b1;
        sending_n = 1'b1;
        datacmd_n = 1'b1;
      end
      default: begin
        trigger_n = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: all state here is plain registers (no memory arrays), so every
    // flop is cleared by the asynchronous reset.
    if (!reset) begin
      state        <= ST_IDLE;
      sym_cnt      <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      packet_count <= '0;
      trigger      <= 1'b0;
      sending      <= 1'b0;
      head         <= 1'b0;
      datacmd      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state        <= state_n;
      sym_cnt      <= sym_n;
      bit_cnt      <= bit_n;
      gap_cnt      <= gap_n;
      packet_count <= count_n;
      trigger      <= trigger_n;
      sending      <= sending_n;
      head         <= head_n;
      datacmd      <= datacmd_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_hitchhike_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hitchhike_tx_scheduler
//
// Scoreboard bench for hitchhike_tx_scheduler at default parameters.
// Stimulus pushes one expected record per trigger-high segment (length,
// done/busy/packet_count at the falling cycle); the monitor checks the
// head/datacmd waveform cycle by cycle against a symbol model and pops a
// record each time trigger falls. Build with +define+TX_REPEAT_EN to run
// the back-to-back scenario instead of the single-packet scenarios.
// -----------------------------------------------------------------------------
module tb_hitchhike_tx_scheduler;

  localparam int SYM       = 50;
  localparam int PRE_BITS  = 8;
  localparam int PAY_BITS  = 144;
  localparam int PKT_LEN   = (PRE_BITS + PAY_BITS) * SYM;  // 7600
  localparam int GAP       = 100;
  localparam logic [7:0] PATTERN = 8'hA5;
  localparam int MAX_WAIT  = 20000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        trigger;
  logic        sending;
  logic        head;
  logic        datacmd;
  logic        busy;
  logic        done;
  logic [15:0] packet_count;

  hitchhike_tx_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .trigger      (trigger),
    .sending      (sending),
    .head         (head),
    .datacmd      (datacmd),
    .busy         (busy),
    .done         (done),
    .packet_count (packet_count)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    int          len;
    logic        done;
    logic        busy;
    logic [15:0] cnt;
  } pkt_t;

  pkt_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   exp_dones = 0;
  int   done_seen = 0;
  int   cycle     = 0;
  int   done_times[$];
  int   low_runs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int len, input logic d, input logic b, input logic [15:0] c);
    pkt_t p;
    p.len  = len;
    p.done = d;
    p.busy = b;
    p.cnt  = c;
    exp_q.push_back(p);
    if (d) exp_dones++;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // ---------------------------------------------------------------------------
  logic trig_prev = 1'b0;
  int   trig_len  = 0;
  int   low_len   = 0;
  int   wave_err  = 0;

  always @(negedge clock) begin
    int   sym;
    logic exp_head;
    logic exp_dc;
    pkt_t p;
    cycle++;
    if (done === 1'b1) begin
      done_seen++;
      done_times.push_back(cycle);
    end
    if (trigger === 1'b1) begin
      if (!trig_prev) begin
        low_runs.push_back(low_len);
        trig_len = 0;
        wave_err = 0;
      end
      sym = trig_len / SYM;
      if (sym < PRE_BITS) begin
        exp_head = PATTERN[PRE_BITS - 1 - sym];
        exp_dc   = 1'b0;
      end else begin
        exp_head = 1'b0;
        exp_dc   = 1'b1;
      end
      if (head !== exp_head || datacmd !== exp_dc || sending !== 1'b1 || busy !== 1'b1)
        wave_err++;
      trig_len++;
    end else begin
      if (trig_prev) begin
        low_len = 0;
        check("waveform_errors", wave_err, 0);
        check("expected_packet_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("trigger_length", trig_len, p.len);
          check("done_at_fall", done, p.done);
          check("busy_at_fall", busy, p.busy);
          check("packet_count_at_fall", packet_count, p.cnt);
          check("sending_low_at_fall", {sending, head, datacmd}, 3'b000);
        end
      end
      low_len++;
    end
    trig_prev = trigger;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs driven on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Pulses start; returns at the first trigger-high cycle (trigger index 0).
  task automatic start_packet(input string name);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check(name, {trigger, sending, busy}, 3'b111);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((trigger !== 1'b0 || busy !== 1'b0) && n < MAX_WAIT) begin
      @(negedge clock);
      n++;
    end
    check(name, n < MAX_WAIT, 1);
    repeat (5) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int err;

    // Reset with all inputs low: everything stays at zero.
    err = 0;
    repeat (20) begin
      @(negedge clock);
      if ({trigger, sending, head, datacmd, busy, done} !== 6'b0 || packet_count !== 16'd0)
        err++;
    end
    reset = 1'b1;
    repeat (5) @(negedge clock);
    if ({trigger, sending, head, datacmd, busy, done} !== 6'b0 || packet_count !== 16'd0)
      err++;
    check("reset_outputs_zero", err, 0);
    enable = 1'b1;

`ifdef TX_REPEAT_EN
    // Back-to-back packets while enable stays high.
    begin
      int n;
      do_reset();
      done_times.delete();
      low_runs.delete();
      push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd1);
      push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd2);
      push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd3);
      start_packet("repeat_start_latency");
      n = 0;
      while (packet_count !== 16'd3 && n < 3 * MAX_WAIT) begin
        @(negedge clock);
        n++;
      end
      check("repeat_three_packets", n < 3 * MAX_WAIT, 1);
      enable = 1'b0;
      repeat (2 * GAP) @(negedge clock);
      check("repeat_done_count", done_times.size(), 3);
      check("repeat_rise_count", low_runs.size(), 3);
      if (done_times.size() == 3) begin
        check("repeat_done_spacing_1", done_times[1] - done_times[0], PKT_LEN + GAP);
        check("repeat_done_spacing_2", done_times[2] - done_times[1], PKT_LEN + GAP);
      end
      if (low_runs.size() == 3) begin
        check("repeat_gap_1", low_runs[1], GAP);
        check("repeat_gap_2", low_runs[2], GAP);
      end
      check("repeat_final_count", packet_count, 16'd3);
      check("repeat_busy_after_stop", busy, 0);
    end
`else
    // One packet at defaults.
    do_reset();
    push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd1);
    start_packet("single_start_latency");
    wait_idle("single_completes");
    check("single_count", packet_count, 16'd1);

    // A second start 1000 cycles into the packet is ignored.
    do_reset();
    push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd1);
    start_packet("ignore_start_latency");
    repeat (1000) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle("ignore_completes");
    repeat (300) @(negedge clock);
    check("ignore_count", packet_count, 16'd1);
    check("ignore_trigger_low", trigger, 0);

    // enable dropped during payload symbol 10 (trigger index 905).
    do_reset();
    push_pkt((PRE_BITS + 10) * SYM + 6, 1'b0, 1'b0, 16'd0);
    start_packet("abort_start_latency");
    repeat ((PRE_BITS + 10) * SYM + 5) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_outputs_low", {trigger, sending, busy, done}, 4'b0000);
    repeat (10) @(negedge clock);
    check("abort_count", packet_count, 16'd0);
    enable = 1'b1;

    // Async reset mid-preamble at trigger index 120, then a fresh packet.
    do_reset();
    push_pkt(121, 1'b0, 1'b0, 16'd0);
    start_packet("rst_start_latency");
    repeat (120) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_outputs_low", {trigger, sending, head, datacmd, busy}, 5'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_stays_idle", busy, 0);
    push_pkt(PKT_LEN, 1'b1, 1'b1, 16'd1);
    start_packet("rst_restart_latency");
    check("rst_restart_first_head", head, PATTERN[7]);
    wait_idle("rst_restart_completes");
`endif

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("total_done_pulses", done_seen, exp_dones);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
